sipo_deser: RTL and testbench

Serial-to-parallel deserializer that sits directly downstream of the 4-bit load/shift register stage. It consumes that stage's serial bit stream, reassembles MSB-first words of `WIDTH` bits, and buffers the completed words in a small FIFO. Words leave through a valid/ready handshake, and sticky flags report framing errors and overflow.

---
 rtl/sipo_deser.sv | 216 +++++++++++++++++++++
 tb/tb_sipo_deser.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/sipo_deser.sv
// Serial MSB-first bit stream to WIDTH-bit words, queued in a DEPTH-entry FIFO; word visible one cycle after its last bit.
// Backpressure via o_valid/i_ready; a word completing into a full FIFO with no pop is dropped and flagged in o_ovf.

module sipo_fifo #(
  parameter int W     = 4,
  parameter int DEPTH = 2
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         wr_vld,
  input  logic [W-1:0] wr_dat,
  output logic         wr_rdy,
  output logic         rd_vld,
  input  logic         rd_rdy,
  output logic [W-1:0] rd_dat
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         full;
  logic         empty;
  logic         do_wr;
  logic         do_rd;

  // Extra pointer MSB distinguishes full from empty when the addresses match.
  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_vld = !empty;
  assign do_rd  = rd_vld && rd_rdy;
  assign wr_rdy = !full || do_rd;
  assign do_wr  = wr_vld && wr_rdy;
  assign rd_dat = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_wr) begin
        mem[wr_ptr[AW-1:0]] <= wr_dat;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

module sipo_deser #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_bit_vld,
  input  logic             i_bit,
  input  logic             i_sof,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_ovf,
  output logic             o_frm_err,
  input  logic             i_clr
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] sr_d;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;
  logic [CW-1:0]    cnt_inc;
  logic [WIDTH:0]   sr_ext;
  logic [WIDTH-1:0] shifted;
  logic             word_done;
  logic             push;
  logic             frm_set;
  logic             ovf_set;
  logic             fifo_wr_rdy;

  // Widened concat keeps the shift legal even when WIDTH is 1.
  assign sr_ext  = {sr_q, i_bit};
  assign shifted = sr_ext[WIDTH-1:0];
  assign cnt_inc = cnt_q + CW'(1);

  always_comb begin
    word_done = 1'b0;
    if (i_bit_vld) begin
      if (state_q == IDLE) begin
        word_done = i_sof && (WIDTH == 1);
      end else begin
        word_done = !i_sof && (cnt_inc == CW'(WIDTH));
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (i_bit_vld && i_sof && !word_done) begin
          state_d = COLLECT;
        end
      end
      COLLECT: begin
        if (word_done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    push    = 1'b0;
    frm_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_bit_vld && i_sof) begin
          sr_d  = shifted;
          cnt_d = word_done ? '0 : CW'(1);
          push  = word_done;
        end
      end
      COLLECT: begin
        if (i_bit_vld) begin
          sr_d = shifted;
          if (i_sof) begin
            // Partial word abandoned; this bit becomes the new MSB.
            frm_set = 1'b1;
            cnt_d   = CW'(1);
          end else if (word_done) begin
            cnt_d = '0;
            push  = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      default: begin
        cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

  sipo_fifo #(
    .W     (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .wr_vld  (push),
    .wr_dat  (shifted),
    .wr_rdy  (fifo_wr_rdy),
    .rd_vld  (o_valid),
    .rd_rdy  (i_ready),
    .rd_dat  (o_data)
  );

  assign ovf_set = push && !fifo_wr_rdy;

  // Set takes priority over a same-cycle clear.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_ovf     <= 1'b0;
      o_frm_err <= 1'b0;
    end else begin
      if (ovf_set) begin
        o_ovf <= 1'b1;
      end else if (i_clr) begin
        o_ovf <= 1'b0;
      end
      if (frm_set) begin
        o_frm_err <= 1'b1;
      end else if (i_clr) begin
        o_frm_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sipo_deser.sv
// Directed-vector bench for sipo_deser (WIDTH=4, DEPTH=2); inputs change and outputs are sampled on the falling edge.

module tb_sipo_deser;

  logic       i_clk;
  logic       i_rst_n;
  logic       i_bit_vld;
  logic       i_bit;
  logic       i_sof;
  logic [3:0] o_data;
  logic       o_valid;
  logic       i_ready;
  logic       o_ovf;
  logic       o_frm_err;
  logic       i_clr;

  int n_vec;
  int n_err;

  sipo_deser #(
    .WIDTH (4),
    .DEPTH (2)
  ) dut (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_bit_vld (i_bit_vld),
    .i_bit     (i_bit),
    .i_sof     (i_sof),
    .o_data    (o_data),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .o_ovf     (o_ovf),
    .o_frm_err (o_frm_err),
    .i_clr     (i_clr)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  // Called at a falling edge; presents one bit for exactly one rising edge.
  task automatic send_bit(input logic b, input logic sof);
    i_bit_vld = 1'b1;
    i_bit     = b;
    i_sof     = sof;
    @(negedge i_clk);
    i_bit_vld = 1'b0;
    i_bit     = 1'b0;
    i_sof     = 1'b0;
  endtask

  task automatic send_word(input logic [3:0] w, input int gap);
    for (int i = 0; i < 4; i++) begin
      send_bit(w[3-i], i == 0);
      if (i < 3) idle(gap);
    end
  endtask

  initial begin
    logic [3:0] c_word;
    n_vec     = 0;
    n_err     = 0;
    i_rst_n   = 1'b0;
    i_bit_vld = 1'b0;
    i_bit     = 1'b0;
    i_sof     = 1'b0;
    i_ready   = 1'b0;
    i_clr     = 1'b0;

    // Reset state
    #3;
    chk("rst_valid", 32'(o_valid), 0);
    chk("rst_data", 32'(o_data), 0);
    chk("rst_ovf", 32'(o_ovf), 0);
    chk("rst_frm", 32'(o_frm_err), 0);
    idle(2);
    i_rst_n = 1'b1;
    idle(1);

    // Single word 1010
    i_ready = 1'b1;
    send_word(4'hA, 0);
    chk("single_valid", 32'(o_valid), 1);
    chk("single_data", 32'(o_data), 'hA);
    idle(1);
    chk("single_one_cycle", 32'(o_valid), 0);
    chk("single_ovf", 32'(o_ovf), 0);
    chk("single_frm", 32'(o_frm_err), 0);

    // Back-to-back A,5 then 3 with 2-cycle gaps
    send_word(4'hA, 0);
    chk("b2b_a_valid", 32'(o_valid), 1);
    chk("b2b_a_data", 32'(o_data), 'hA);
    send_word(4'h5, 0);
    chk("b2b_5_valid", 32'(o_valid), 1);
    chk("b2b_5_data", 32'(o_data), 'h5);
    send_word(4'h3, 2);
    chk("gap_3_valid", 32'(o_valid), 1);
    chk("gap_3_data", 32'(o_data), 'h3);
    idle(1);
    chk("gap_drained", 32'(o_valid), 0);

    // Overflow: A,5,C into a 2-deep FIFO with no consumer
    i_ready = 1'b0;
    send_word(4'hA, 0);
    send_word(4'h5, 0);
    chk("ovf_before_c", 32'(o_ovf), 0);
    send_word(4'hC, 0);
    chk("ovf_set", 32'(o_ovf), 1);
    chk("ovf_head_a", 32'(o_data), 'hA);
    i_ready = 1'b1;
    idle(1);
    chk("ovf_next_valid", 32'(o_valid), 1);
    chk("ovf_next_5", 32'(o_data), 'h5);
    idle(1);
    chk("ovf_c_lost", 32'(o_valid), 0);
    chk("ovf_sticky", 32'(o_ovf), 1);
    i_clr = 1'b1;
    idle(1);
    i_clr = 1'b0;
    chk("ovf_cleared", 32'(o_ovf), 0);

    // Full FIFO, C completes on the same edge as a pop
    i_ready = 1'b0;
    send_word(4'hA, 0);
    send_word(4'h5, 0);
    c_word = 4'hC;
    for (int i = 0; i < 3; i++) send_bit(c_word[3-i], i == 0);
    i_ready = 1'b1;
    send_bit(c_word[0], 1'b0);
    chk("simul_no_ovf", 32'(o_ovf), 0);
    chk("simul_head_5", 32'(o_data), 'h5);
    idle(1);
    chk("simul_valid_c", 32'(o_valid), 1);
    chk("simul_head_c", 32'(o_data), 'hC);
    idle(1);
    chk("simul_empty", 32'(o_valid), 0);

    // Stray bits in IDLE are discarded silently
    i_ready = 1'b0;
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    idle(1);
    chk("stray_valid", 32'(o_valid), 0);
    chk("stray_frm", 32'(o_frm_err), 0);

    // Framing error: 1,1 then restart with 0110; clear in the same cycle loses to set
    send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b0);
    i_clr = 1'b1;
    send_bit(1'b0, 1'b1);
    i_clr = 1'b0;
    chk("frm_set_wins", 32'(o_frm_err), 1);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    chk("frm_valid", 32'(o_valid), 1);
    chk("frm_word_6", 32'(o_data), 'h6);
    i_ready = 1'b1;
    idle(1);
    chk("frm_single_word", 32'(o_valid), 0);

    // Reset mid-word with one word queued and frm_err still set
    i_ready = 1'b0;
    send_word(4'hA, 0);
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    chk("pre_rst_valid", 32'(o_valid), 1);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(o_valid), 0);
    chk("arst_data", 32'(o_data), 0);
    chk("arst_frm", 32'(o_frm_err), 0);
    chk("arst_ovf", 32'(o_ovf), 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    idle(1);
    i_ready = 1'b1;
    send_word(4'h9, 0);
    chk("post_rst_valid", 32'(o_valid), 1);
    chk("post_rst_data", 32'(o_data), 'h9);
    chk("post_rst_frm", 32'(o_frm_err), 0);
    idle(1);
    chk("post_rst_empty", 32'(o_valid), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
